// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings for the unified IF/MEM memory arbiter: FSM states, grant ids, NOP word.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_t;

  // addi x0, x0, 0 -- returned in place of data when the bus times out
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/unified_mem_arbiter_mem_timeout_ctr.sv
// Busy-cycle counter; done is high in the cycle the count reaches TIMEOUT-1 while enabled.
// Combinational done, no backpressure; TIMEOUT=0 never signals done.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  assign done = (TIMEOUT > 0) && enable && (count == LAST);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one req/ack memory between fetch and load/store; grant 1 cycle after request,
// valid 1 cycle after ack (or timeout). Requesters are backpressured by holding their request until valid.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              TIMEOUT  = 64,
  parameter logic [XLEN-1:0] ERR_DATA = XLEN'(NOP_INSN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            flush,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_valid,
  output logic            if_stall,
  input  logic            dm_read,
  input  logic            dm_write,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_valid,
  output logic            dm_stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            bus_err
);

  arb_state_t      state, next;
  gnt_t            last, sel;
  logic            grant;
  logic            squash;
  logic            busy;
  logic            tmo_done;
  logic            dm_pend, if_pend;
  logic            finish;
  logic [XLEN-1:0] cap_data;

  assign dm_pend  = dm_read | dm_write;
  assign if_pend  = if_req & ~flush;
  assign busy     = (state == BUSY_I) || (state == BUSY_D);
  assign finish   = mem_ack || tmo_done;
  assign cap_data = mem_ack ? mem_rdata : ERR_DATA;

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (~busy),
    .enable(busy),
    .done  (tmo_done)
  );

  always_comb begin
    next  = state;
    grant = 1'b0;
    sel   = last;
    case (state)
      IDLE: begin
        if (dm_pend || if_pend) begin
          grant = 1'b1;
          if (dm_pend && if_pend) begin
            sel = (last == GNT_IF) ? GNT_DM : GNT_IF;
          end else begin
            sel = dm_pend ? GNT_DM : GNT_IF;
          end
          next = (sel == GNT_DM) ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (finish) next = DONE;
      end
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= GNT_IF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      bus_err   <= 1'b0;
      squash    <= 1'b0;
    end else begin
      state <= next;
      case (state)
        IDLE: begin
          if (grant) begin
            last    <= sel;
            mem_req <= 1'b1;
            if (sel == GNT_DM) begin
              mem_we    <= dm_write;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= if_addr;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (state == BUSY_I && flush) squash <= 1'b1;
          if (finish) begin
            mem_req <= 1'b0;
            if (!mem_ack) bus_err <= 1'b1;
            // a fetch flushed in its final cycle must not overwrite the last good instruction
            if (state == BUSY_I && !squash && !flush) if_rdata <= cap_data;
            if (state == BUSY_D && !mem_we) dm_rdata <= cap_data;
          end
        end
        DONE:    squash <= 1'b0;
        default: ;
      endcase
    end
  end

  // flush arriving in DONE still has to kill the already-registered fetch result
  assign if_valid = (state == DONE) && (last == GNT_IF) && !squash && !flush;
  assign dm_valid = (state == DONE) && (last == GNT_DM);
  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_pend & ~dm_valid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboarded randomized bench for unified_mem_arbiter: reference memory + queues, independent monitor.
module tb_unified_mem_arbiter;

  typedef struct packed {
    logic        store;
    logic [31:0] data;
  } dm_exp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  logic        clk;
  logic        reset;
  logic        if_req, flush;
  logic [31:0] if_addr, if_rdata;
  logic        if_valid, if_stall;
  logic        dm_read, dm_write;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_valid, dm_stall;
  logic        mem_req, mem_we, mem_ack, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_arr [256];
  logic [31:0] ref_mem [256];
  logic [31:0] if_q [$];
  dm_exp_t     dm_q [$];
  grant_t      grant_log [$];
  logic [31:0] last_load, last_fetch;

  int   lat_min, lat_max;
  logic ack_en, stray_ack;

  unified_mem_arbiter #(
    .XLEN(32),
    .TIMEOUT(4),
    .ERR_DATA(32'h0000_0013)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'h1234_5678;
    if (i == 64) return 32'hDEAD_BEEF;
    return 32'(i) * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: acks after lat_min..lat_max extra cycles, writes on ack.
  initial begin : responder
    int cnt;
    int cur_lat;
    cnt = 0;
    cur_lat = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (stray_ack) begin
        mem_ack = 1'b1;
      end else if (mem_req && ack_en) begin
        if (cnt == 0) cur_lat = int'($urandom_range(lat_max, lat_min));
        if (cnt == cur_lat) begin
          mem_ack = 1'b1;
          cnt = 0;
          if (mem_we) begin
            mem_arr[mem_addr[9:2]] = mem_wdata;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = mem_arr[mem_addr[9:2]];
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: scoreboard pops, memory-port stability and grant logging.
  initial begin : monitor
    logic        prev_req, prev_we;
    logic [31:0] prev_addr, prev_wdata;
    dm_exp_t     e;
    prev_req = 1'b0;
    prev_we = 1'b0;
    prev_addr = '0;
    prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (if_valid) begin
        if (if_q.size() == 0) check("if_valid_unexpected", {31'd0, if_valid}, 32'd0);
        else check("if_rdata", if_rdata, if_q.pop_front());
      end
      if (dm_valid) begin
        if (dm_q.size() == 0) begin
          check("dm_valid_unexpected", {31'd0, dm_valid}, 32'd0);
        end else begin
          e = dm_q.pop_front();
          if (e.store) check("dm_rdata_after_store", dm_rdata, e.data);
          else check("dm_rdata", dm_rdata, e.data);
        end
      end
      if (mem_req && prev_req && !reset) begin
        check("mem_addr_stable", mem_addr, prev_addr);
        check("mem_we_stable", {31'd0, mem_we}, {31'd0, prev_we});
        check("mem_wdata_stable", mem_wdata, prev_wdata);
      end
      if (mem_req && !prev_req) grant_log.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
      prev_req = mem_req;
      prev_we = mem_we;
      prev_addr = mem_addr;
      prev_wdata = mem_wdata;
    end
  end

  // Entered and left at posedge+1; leaves the request dropped.
  task automatic if_txn(input logic [31:0] a, output int vcyc, output int stallc);
    logic [31:0] exp;
    exp = ref_mem[a[9:2]];
    if_q.push_back(exp);
    if_req = 1'b1;
    if_addr = a;
    vcyc = -1;
    stallc = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (if_stall) stallc++;
      if (if_valid) begin
        vcyc = c;
        break;
      end
    end
    @(posedge clk);
    #1;
    if_req = 1'b0;
    if (vcyc >= 0) last_fetch = exp;
    check("if_complete", (vcyc < 0) ? 0 : 1, 1);
  endtask

  task automatic dm_txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic tmo, output int vcyc, output int reqc, output int stallc);
    dm_exp_t e;
    int we_bad;
    if (wr) begin
      ref_mem[a[9:2]] = d;
      e.store = 1'b1;
      e.data = last_load;
    end else begin
      e.store = 1'b0;
      e.data = tmo ? 32'h0000_0013 : ref_mem[a[9:2]];
      last_load = e.data;
    end
    dm_q.push_back(e);
    dm_read = rd;
    dm_write = wr;
    dm_addr = a;
    dm_wdata = d;
    vcyc = -1;
    reqc = 0;
    stallc = 0;
    we_bad = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (mem_req && mem_addr[9:8] != 2'b00) begin
        reqc++;
        if (mem_we != wr) we_bad++;
      end
      if (dm_stall) stallc++;
      if (dm_valid) begin
        vcyc = c;
        break;
      end
    end
    @(posedge clk);
    #1;
    dm_read = 1'b0;
    dm_write = 1'b0;
    check("dm_complete", (vcyc < 0) ? 0 : 1, 1);
    check("dm_mem_we", we_bad, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if_req = 1'b0;
    dm_read = 1'b0;
    dm_write = 1'b0;
    flush = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    last_load = '0;
    last_fetch = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check({tag, "_mem_req"},   {31'd0, mem_req}, 32'd0);
    check({tag, "_mem_we"},    {31'd0, mem_we}, 32'd0);
    check({tag, "_if_valid"},  {31'd0, if_valid}, 32'd0);
    check({tag, "_dm_valid"},  {31'd0, dm_valid}, 32'd0);
    check({tag, "_bus_err"},   {31'd0, bus_err}, 32'd0);
    check({tag, "_mem_addr"},  mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_if_rdata"},  if_rdata, 32'd0);
    check({tag, "_dm_rdata"},  dm_rdata, 32'd0);
  endtask

  initial begin : main
    int v1, s1, v2, r2, s2, vcnt;
    logic [31:0] wd;
    reset = 1'b1;
    if_req = 1'b0;
    if_addr = '0;
    flush = 1'b0;
    dm_read = 1'b0;
    dm_write = 1'b0;
    dm_addr = '0;
    dm_wdata = '0;
    ack_en = 1'b1;
    stray_ack = 1'b0;
    lat_min = 0;
    lat_max = 0;
    last_load = '0;
    last_fetch = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    @(posedge clk);
    #1;
    do_reset();
    check_reset_vals("reset");
    @(posedge clk);
    #1;

    // single load, zero-wait memory
    dm_txn(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, v2, r2, s2);
    check("load_valid_cycle", v2, 2);
    check("load_req_cycles", r2, 1);
    check("load_stall_cycles", s2, 2);

    // single fetch
    if_txn(32'h8, v1, s1);
    check("fetch_valid_cycle", v1, 2);
    check("fetch_stall_cycles", s1, 2);

    // contention from reset: store first, then strict alternation
    do_reset();
    grant_log.delete();
    fork
      begin
        int a1, b1;
        if_txn(32'h0, a1, b1);
        if_txn(32'h4, a1, b1);
      end
      begin
        int a2, b2, c2;
        dm_txn(1'b0, 1'b1, 32'h200, 32'h55, 1'b0, a2, b2, c2);
        dm_txn(1'b1, 1'b0, 32'h204, 32'h0, 1'b0, a2, b2, c2);
      end
    join
    check("rr_grants", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      check("rr_g0_addr", grant_log[0].addr, 32'h200);
      check("rr_g0_we", {31'd0, grant_log[0].we}, 32'd1);
      check("rr_g0_wdata", grant_log[0].wdata, 32'h55);
      check("rr_g1_addr", grant_log[1].addr, 32'h0);
      check("rr_g1_we", {31'd0, grant_log[1].we}, 32'd0);
      check("rr_g2_addr", grant_log[2].addr, 32'h204);
      check("rr_g3_addr", grant_log[3].addr, 32'h4);
    end

    // flush during BUSY_I squashes the fetch
    lat_min = 2;
    lat_max = 2;
    if_req = 1'b1;
    if_addr = 32'h40;
    @(posedge clk);
    #1;
    flush = 1'b1;
    if_req = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    vcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (if_valid) vcnt++;
    end
    check("flush_no_valid", vcnt, 0);
    check("flush_if_rdata_kept", if_rdata, last_fetch);
    @(posedge clk);
    #1;
    lat_min = 0;
    lat_max = 0;
    dm_txn(1'b1, 1'b0, 32'h110, 32'h0, 1'b0, v2, r2, s2);
    check("after_flush_idle", v2, 2);

    // slow memory: ack on the 4th request cycle
    lat_min = 3;
    lat_max = 3;
    wd = $urandom;
    dm_txn(1'b0, 1'b1, 32'h10C, wd, 1'b0, v2, r2, s2);
    check("slow_store_valid_cycle", v2, 5);
    check("slow_store_req_cycles", r2, 4);
    dm_txn(1'b1, 1'b0, 32'h10C, 32'h0, 1'b0, v2, r2, s2);
    check("slow_load_valid_cycle", v2, 5);
    check("no_bus_err_yet", {31'd0, bus_err}, 32'd0);

    // timeout
    ack_en = 1'b0;
    dm_txn(1'b1, 1'b0, 32'h104, 32'h0, 1'b1, v2, r2, s2);
    check("tmo_valid_cycle", v2, 5);
    check("tmo_req_cycles", r2, 4);
    check("tmo_bus_err", {31'd0, bus_err}, 32'd1);
    ack_en = 1'b1;
    lat_min = 0;
    lat_max = 1;
    dm_txn(1'b1, 1'b0, 32'h120, 32'h0, 1'b0, v2, r2, s2);
    check("bus_err_sticky", {31'd0, bus_err}, 32'd1);

    // reset while BUSY_D, then a stray ack
    ack_en = 1'b0;
    dm_read = 1'b1;
    dm_addr = 32'h108;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("busy_before_reset", {31'd0, mem_req}, 32'd1);
    do_reset();
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    check_reset_vals("midrst_a");
    check_reset_vals("midrst_b");
    @(posedge clk);
    #1;
    ack_en = 1'b1;

    // randomized concurrent traffic
    lat_min = 0;
    lat_max = 3;
    fork
      begin
        int a1, b1;
        for (int k = 0; k < 25; k++) begin
          if_txn(32'($urandom_range(0, 63)) << 2, a1, b1);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
      end
      begin
        int a2, b2, c2, op;
        for (int k = 0; k < 25; k++) begin
          op = int'($urandom_range(0, 2));
          dm_txn(op != 1, op != 0, 32'($urandom_range(64, 255)) << 2, $urandom, 1'b0, a2, b2, c2);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
      end
    join

    repeat (4) @(negedge clk);
    check("if_queue_drained", if_q.size(), 0);
    check("dm_queue_drained", dm_q.size(), 0);
    check("final_bus_err", {31'd0, bus_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the IF stage (fetch, read-only) and the MEM stage (load/store) of the pipelined processor.
- Serializes accesses, drives a req/ack memory port and returns per-requester stall and valid signals to the hazard logic.
- Round-robin fairness, fetch-flush squashing and a bus timeout with a sticky error flag.
- Sits between the pipeline stages and the memory model, replacing the separate instruction and data memories.

Parameters:
- XLEN, 32, address/data width.
- TIMEOUT, 64, maximum cycles in a busy state without mem_ack; 0 disables the timeout.
- ERR_DATA, 32'h0000_0013, read data returned on a timeout (encodes NOP).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- if_req  in  1  fetch request, held until if_valid.
- if_addr  in  XLEN  fetch byte address.
- flush  in  1  branch taken; squash the fetch.
- if_rdata  out  XLEN  fetched instruction, registered.
- if_valid  out  1  one-cycle pulse, if_rdata valid.
- if_stall  out  1  combinational: if_req & ~if_valid.
- dm_read  in  1  load request, held until dm_valid.
- dm_write  in  1  store request, held until dm_valid.
- dm_addr  in  XLEN  data byte address.
- dm_wdata  in  XLEN  store data.
- dm_rdata  out  XLEN  load data, registered.
- dm_valid  out  1  one-cycle completion pulse (loads and stores).
- dm_stall  out  1  combinational: (dm_read|dm_write) & ~dm_valid.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  write enable, qualified by mem_req.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  memory write data.
- mem_rdata  in  XLEN  memory read data, sampled with mem_ack.
- mem_ack  in  1  memory completion, may assert in the first cycle mem_req is high.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset: state IDLE, last-grant = IF. mem_req, mem_we, if_valid, dm_valid and bus_err are 0. mem_addr, mem_wdata, if_rdata and dm_rdata are 0. Timeout counter is 0.
- Reset mid-transaction: the request is abandoned and mem_req is 0 after the edge. A late mem_ack is ignored.

States:
- IDLE:
  - Grant candidates are dm (dm_read|dm_write) and if (if_req & ~flush).
  - Both pending: grant the one not granted last. One pending: grant it. None: stay.
  - On grant: register addr, we (dm_write) and wdata; set mem_req=1; update last-grant; go to BUSY_D or BUSY_I.
- BUSY_I / BUSY_D:
  - mem_req and the address/data outputs are held stable.
  - Timeout counter increments each cycle.
  - On mem_ack: capture mem_rdata into if_rdata (BUSY_I) or dm_rdata (BUSY_D; loads only, a store leaves dm_rdata unchanged). Set mem_req=0 and go to DONE.
  - On counter == TIMEOUT-1 without ack (TIMEOUT>0): capture ERR_DATA instead, set bus_err=1, mem_req=0, go to DONE.
- DONE:
  - Exactly one cycle. Pulse if_valid or dm_valid for the serviced requester.
  - No grant is made, so a requester still holding its request is not re-served. Next state is IDLE.
  - Counter is cleared.

Flush:
- flush in IDLE blocks the IF grant that cycle.
- flush in BUSY_I or DONE(I) sets a squash bit: the memory access still completes, but if_valid is suppressed and if_rdata is not updated. Squash clears on entering IDLE.

Other rules:
- dm_read & dm_write together: treated as a store.
- Addresses are passed through unmodified; no alignment check.
- mem_ack in IDLE or DONE is ignored.
- Minimum access latency is request-visible cycle N, mem_req at N+1, ack at N+1, valid at N+2; next grant at N+3.
- bus_err clears only on reset.

Decomposition:
- Shared package holds the state encoding (IDLE, BUSY_I, BUSY_D, DONE), the grant-id constants (GNT_IF, GNT_DM) and the NOP encoding used for ERR_DATA.
- One sub-module is natural: mem_timeout_ctr (clear, enable, done output, parameter TIMEOUT).

Test Plan:
- Single load: dm_read, addr 0x100, memory acks in the first mem_req cycle with 0xDEADBEEF -> mem_req high for 1 cycle with mem_we=0; dm_valid pulses 2 cycles after request; dm_rdata=0xDEADBEEF; dm_stall high for 2 cycles.
- Contention from reset: if_req (0x0) and dm_write (0x200, 0x55) on the same cycle -> store is granted first (mem_we=1, addr 0x200), then fetch at 0x0. While both are repeatedly pending, grants alternate D, I, D, I.
- Flush mid-fetch: if_req at 0x40, flush during BUSY_I, ack with 0x12345678 -> if_valid is never asserted, if_rdata is unchanged, and the arbiter returns to IDLE.
- Timeout: TIMEOUT=4, mem_ack tied to 0, dm_read -> mem_req high for exactly 4 cycles; dm_valid pulses with dm_rdata=0x00000013; bus_err=1 and stays 1 until reset.
- Reset mid-operation: assert reset while in BUSY_D, then a stray mem_ack -> mem_req=0, all outputs at reset values, no valid pulse.
- Slow memory: ack 3 cycles after mem_req rises -> mem_addr, mem_we and mem_wdata are stable throughout; exactly one dm_valid pulse.
